// File: rtl/temp_conv_c2f.sv
// ADT7420 raw temperature word to integer Celsius and Fahrenheit for the two-digit display.
// Fahrenheit uses a shift-add multiply by 9 and a 16-cycle restoring divide by 5.
module temp_conv_c2f #(
   parameter int unsigned CLAMP_MAX  = 99,
   parameter int unsigned F_OFFSET16 = 512
) (
   input  logic        clk_100MHz,
   input  logic        reset_n,
   input  logic [15:0] raw_temp,
   input  logic        raw_valid,
   output logic        busy,
   output logic [7:0]  c_data,
   output logic [7:0]  f_data,
   output logic        data_valid,
   output logic        overrun
);

   localparam logic [7:0]         ClampC  = 8'(CLAMP_MAX);
   localparam logic [10:0]        ClampF  = 11'(CLAMP_MAX);
   localparam logic signed [14:0] Offset  = 15'(F_OFFSET16);
   localparam logic [3:0]         Divisor = 4'd5;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StOut} state_e;

   state_e      state_q, state_d;
   logic [12:0] t_q, t_d;
   logic [13:0] mag_q, mag_d;
   // Dividend bits leave at the MSB while quotient bits enter at the LSB.
   logic [15:0] div_q, div_d;
   logic [2:0]  rem_q, rem_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  c_q, c_d;
   logic [7:0]  f_q, f_d;
   logic        dv_q, dv_d;
   logic        ov_q, ov_d;

   logic [13:0]        t_ext;
   logic [3:0]         trial;
   logic [3:0]         trial_sub;
   logic               trial_ge;
   logic signed [14:0] q_s;
   logic signed [14:0] f16;
   logic [10:0]        f_int;
   logic [7:0]         c_sat;
   logic [7:0]         f_sat;
   logic               unused_bits;

   assign unused_bits = ^{raw_temp[2:0], t_q[3:0], f16[3:0], trial_sub[3]};

   always_comb begin
      t_ext     = {raw_temp[15], raw_temp[15:3]};
      trial     = {rem_q, div_q[15]};
      trial_ge  = (trial >= Divisor);
      trial_sub = trial - Divisor;
      q_s       = $signed({2'b00, div_q[12:0]});
      f16       = t_q[12] ? (Offset - q_s) : (Offset + q_s);
      f_int     = f16[14:4];
      if (f16 <= 15'sd0) begin
         f_sat = '0;
      end else if (f_int > ClampF) begin
         f_sat = ClampF[7:0];
      end else begin
         f_sat = f_int[7:0];
      end
      if (t_q[12]) begin
         c_sat = '0;
      end else if (t_q[11:4] > ClampC) begin
         c_sat = ClampC;
      end else begin
         c_sat = t_q[11:4];
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      mag_d   = mag_q;
      div_d   = div_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      f_d     = f_q;
      dv_d    = 1'b0;
      // Any strobe outside IDLE is dropped and flagged one cycle later.
      ov_d    = raw_valid && (state_q != StIdle);
      case (state_q)
         StIdle: begin
            if (raw_valid) begin
               t_d     = raw_temp[15:3];
               mag_d   = raw_temp[15] ? (~t_ext + 14'd1) : t_ext;
               state_d = StMul;
            end
         end
         StMul: begin
            div_d   = ({2'b00, mag_q} << 3) + {2'b00, mag_q};
            rem_d   = '0;
            cnt_d   = '0;
            state_d = StDiv;
         end
         StDiv: begin
            div_d = {div_q[14:0], trial_ge};
            rem_d = trial_ge ? trial_sub[2:0] : trial[2:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = StOut;
            end
         end
         StOut: begin
            c_d     = c_sat;
            f_d     = f_sat;
            dv_d    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         t_q     <= '0;
         mag_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         c_q     <= '0;
         f_q     <= '0;
         dv_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         mag_q   <= mag_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         f_q     <= f_d;
         dv_q    <= dv_d;
         ov_q    <= ov_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign c_data     = c_q;
   assign f_data     = f_q;
   assign data_valid = dv_q;
   assign overrun    = ov_q;

endmodule

// File: doc/temp_conv_c2f.md
Name: temp_conv_c2f

Overview:
- Sits between the I2C temperature-sensor reader and the two-bank seven-segment display driver.
- Takes the raw 16-bit ADT7420 temperature register word (13-bit mode, 0.0625 °C/LSB) on a valid strobe.
- Produces the registered integer °C value for the display's display_data input and the integer °F value for its f_data input.
- °F is computed with a sequential multiply-by-9 and a 16-step restoring divide-by-5; no combinational divider.

Parameters:
- CLAMP_MAX, 99, upper saturation for both outputs (two-digit display limit); must be ≤ 255.
- F_OFFSET16, 512, 32 °F expressed in 1/16-degree units.

Ports:
- clk_100MHz  input  1  system clock, 100 MHz
- reset_n  input  1  asynchronous active-low reset
- raw_temp  input  16  ADT7420 temp register; bits [15:3] = signed 13-bit t in 1/16 °C; bits [2:0] ignored
- raw_valid  input  1  single-cycle strobe; raw_temp valid this cycle
- busy  output  1  high while a conversion is in progress (any state other than IDLE)
- c_data  output  8  integer °C, clamped to 0..CLAMP_MAX
- f_data  output  8  integer °F, clamped to 0..CLAMP_MAX
- data_valid  output  1  one-cycle pulse; c_data and f_data just updated
- overrun  output  1  one-cycle pulse; raw_valid arrived while busy and the sample was dropped

Behaviour:
- Reset (async, reset_n=0): state=IDLE; c_data=0, f_data=0, busy=0, data_valid=0, overrun=0; all internal registers cleared.
- Reset mid-conversion aborts it immediately. Outputs return to 0 and no data_valid is produced.
- States:
  - IDLE: on raw_valid, latch t=raw_temp[15:3]. Latch sign s=t[12] and mag=|t| (14-bit unsigned, max 4096). Go to MUL.
  - MUL: prod = mag*9, formed as (mag<<3)+mag, 16 bits, max 36864. Load divider. Go to DIV.
  - DIV: 16 iterations of restoring division of prod by 5, one quotient bit per clock, MSB first. After 16 cycles q = floor(prod/5), max 7372. Go to OUT.
  - OUT: register results, pulse data_valid. Go to IDLE.
- Arithmetic, performed in OUT:
  - f16 = s ? F_OFFSET16 - q : F_OFFSET16 + q. Use 15-bit signed.
  - f_data = (f16 ≤ 0) ? 0 : min(f16>>4, CLAMP_MAX). Fraction truncated.
  - c_data = s ? 0 : min(t>>4, CLAMP_MAX). Fraction truncated.
- Latency: raw_valid sampled at clock edge N. Outputs update and data_valid goes high at edge N+18. data_valid stays high for exactly one cycle.
- busy is high from edge N+1 through the cycle ending at edge N+18. busy is low again after the OUT state.
- c_data and f_data hold their last values between conversions. There is no change except in OUT or on reset.
- raw_valid in any non-IDLE state, including OUT, is dropped and pulses overrun the next cycle. The current conversion is unaffected.
- raw_valid held high continuously: a new conversion starts on every IDLE cycle. The other samples overrun.
- raw_temp changing during a conversion has no effect, because the value is latched in IDLE.

Test Plan:
- Reset check: assert reset_n=0 mid-DIV -> c_data=0, f_data=0, busy=0, no data_valid. Then release, raw_temp=0x0C80 (25.0 °C) -> after 18 edges c_data=25, f_data=77, data_valid single pulse.
- Zero and fraction:
  - raw_temp=0x0000 -> c_data=0, f_data=32.
  - raw_temp=0x1240 (36.5 °C) -> c_data=36, f_data=97, truncated from 97.7.
- Negatives:
  - raw_temp=0xFB00 (-10 °C) -> c_data=0, f_data=14.
  - raw_temp=0xEC00 (-40 °C) -> c_data=0, f_data=0.
- Saturation:
  - raw_temp=0x1900 (50 °C) -> c_data=50, f_data=99 (122 clamped).
  - raw_temp=0x4B00 (150 °C) -> c_data=99, f_data=99.
- Overrun: pulse raw_valid=0x0C80, then raw_valid=0x1900 four cycles later -> overrun pulses once. The result is 25/77 only, with exactly one data_valid. A third strobe after busy falls -> 50/99 with no overrun.
- Back-to-back: hold raw_valid high for 40 cycles with a fixed value -> data_valid every 19 cycles, correct values each time, overrun pulsed for every dropped cycle.
